mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised synchronous binary counter for the sequential-circuits library: the general-purpose successor to the fixed 4-bit synchronous toggle counter. It counts up or down with configurable width and modulus, and supports synchronous clear, parallel load and count enable. It provides a combinational terminal-count output for cascading and a registered wrap pulse. It is the standard count/divide element for timers, clock dividers and address sequencers in the design.

## Interface
- `WIDTH`, default 4: counter width in bits, legal 1..32.
- `MODULUS`, default 16: count range 0..MODULUS-1, legal 2..2^WIDTH.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `clr`, input, 1: synchronous clear to 0.
- `en`, input, 1: count enable.
- `up`, input, 1: direction. 1 = up, 0 = down.
- `load`, input, 1: synchronous parallel load.
- `d`, input, WIDTH: load value.
- `q`, output, WIDTH: current count.
- `tc`, output, 1: combinational terminal count, for cascading.
- `wrap`, output, 1: registered one-cycle pulse on wrap-around.
- `ovf`, output, 1: sticky wrap flag. Driven only with the macro, see Configuration.

## Operation
- Reset is asynchronous and active-high. While asserted: `q`=0, `wrap`=0, `ovf`=0. Outputs take these values immediately, independent of `clk`.
- Priority at each rising `clk` edge: `clr` > `load` > `en` > hold.
- `clr`: `q` becomes 0. `wrap` becomes 0. No wrap is recorded.
- `load`: `q` becomes `d` if `d` < MODULUS, otherwise MODULUS-1 (saturating load). `wrap` becomes 0.
- `en` with `up`=1: if `q`=MODULUS-1, `q` becomes 0 and `wrap` becomes 1. Otherwise `q` becomes `q`+1.
- `en` with `up`=0: if `q`=0, `q` becomes MODULUS-1 and `wrap` becomes 1. Otherwise `q` becomes `q`-1.
- No `en`, `clr` or `load`: `q` holds. `wrap` becomes 0.
- `tc` = `en` AND (`up` ? `q`==MODULUS-1 : `q`==0). Purely combinational, not gated by `clr`/`load`.
- Cascading: feed stage N's `tc` into stage N+1's `en`, with a shared `clk`, `reset` and `up`.
- `up` may change on any cycle. A change takes effect at the next edge, with no extra latency.
- When MODULUS = 2^WIDTH, wrap is natural binary overflow and the result must be identical.
- All arithmetic is WIDTH bits. Comparisons use MODULUS-1 cast to WIDTH bits.

## Timing
- Count latency: 1 cycle. `q` reflects `en` at the edge where it was sampled.
- `wrap` is high for exactly the one cycle in which `q` holds the wrapped value (0 going up, MODULUS-1 going down). With `en` held, consecutive wraps give one pulse per period.
- `tc` is valid in the same cycle as `q`/`en`/`up`, with no register stage.
- Reset deassertion: the first count occurs at the first rising edge with `reset` low and `en` high.
- Reset asserted mid-count: state is lost. `wrap` and `ovf` are cleared immediately.

## Configuration
- Macro `MOD_COUNTER_STICKY_OVF_EN`.
- Defined: `ovf` sets at the same edge `wrap` sets. It stays set until `clr` or `reset`. `load` does not clear it.
- Undefined: the `ovf` port remains present and is tied to 0. No sticky register is synthesised.

## Structure
- Shared package `counter_pkg`: typedef `count_dir_t` (`DIR_DOWN`=0, `DIR_UP`=1) and the `MAX_COUNTER_WIDTH`=32 constant.
- Elaboration-time assertions: `WIDTH` and `MODULUS` legal.
- One sub-module, `tff_cell`: a T flip-flop with async active-high reset and Q/nQ outputs.
- `mod_counter` computes the next state and drives each bit's T as next[i] XOR q[i]. This keeps the library's toggle-cell style.

## Test plan
- WIDTH=4, MODULUS=10, `up`=1, `en`=1 for 12 cycles from reset → `q` goes 0..9,0,1. `wrap` is high only in the cycle `q`=0 after 9. `tc`=1 only while `q`=9.
- Same config, `up`=0 from `q`=2 → `q` goes 2,1,0,9,8. `wrap` is high in the cycle `q`=9. `tc`=1 while `q`=0.
- `load`=1 with `d`=7, then `d`=12 → `q`=7, then `q`=9 (saturated load). With `load` and `en` both high, the load wins.
- `clr` and `load` together while `q`=5 → `q`=0. `reset` pulsed mid-count between edges → `q`, `wrap` and `ovf` go to 0 immediately.
- Two WIDTH=4, MODULUS=16 stages cascaded via `tc` → an 8-bit count reaches 0xFF, then 0x00. The upper stage's `wrap` pulses once.
- With `MOD_COUNTER_STICKY_OVF_EN`: a wrap sets `ovf`. A `load` leaves `ovf`=1. A `clr` drops it to 0. Without the macro, `ovf`=0 throughout.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the sequential-circuits counter library.
//   count_dir_t       : count direction, DIR_DOWN = 0, DIR_UP = 1
//   MAX_COUNTER_WIDTH : widest counter the library supports
// -----------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } count_dir_t;

   localparam int MAX_COUNTER_WIDTH = 32;

endpackage : counter_pkg

// File: rtl/mod_counter_tff_cell.sv
// -----------------------------------------------------------------------------
// tff_cell
// Single toggle flip-flop, the storage element of the library's counters.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset (Q -> 0)
//   t_i   : toggle request, sampled at the rising edge
//   q_o   : stored bit
//   nq_o  : complement of the stored bit
// -----------------------------------------------------------------------------
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t_i,
   output logic q_o,
   output logic nq_o
);

   logic q_q;
   logic q_d;

   assign q_d = q_q ^ t_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o  = q_q;
   assign nq_o = ~q_q;

endmodule : tff_cell

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Parametrised modulo-MODULUS up/down counter built from toggle cells.
// Priority at each rising edge: clr_i > load_i > en_i > hold.
//
// Parameters:
//   WIDTH   : counter width, 1..MAX_COUNTER_WIDTH
//   MODULUS : count range 0..MODULUS-1, 2..2**WIDTH
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high reset (q_o, wrap_o, ovf_o -> 0)
//   clr_i   : synchronous clear to 0
//   en_i    : count enable
//   up_i    : direction, 1 = up, 0 = down
//   load_i  : synchronous parallel load (saturates at MODULUS-1)
//   d_i     : load value
//   q_o     : current count
//   tc_o    : combinational terminal count, for cascading into the next en_i
//   wrap_o  : registered one-cycle pulse while q_o holds the wrapped value
//   ovf_o   : sticky wrap flag, cleared by clr_i or reset
//
// Build option: define MOD_COUNTER_STICKY_OVF_EN to implement the sticky ovf_o
// register; otherwise ovf_o is tied to 0.
// -----------------------------------------------------------------------------
module mod_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH   = 4,
   parameter longint MODULUS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             tc_o,
   output logic             wrap_o,
   output logic             ovf_o
);

   // ---------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------
   if (WIDTH < 1 || WIDTH > MAX_COUNTER_WIDTH) begin : g_bad_width
      $error("mod_counter: WIDTH must be in 1..%0d", MAX_COUNTER_WIDTH);
   end
   if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS must be in 2..2**WIDTH");
   end

   // Terminal value, truncated to WIDTH bits so MODULUS = 2**WIDTH gives all ones.
   localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

   count_dir_t       dir;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_n;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] toggle;
   logic [63:0]      d_ext;
   logic [WIDTH-1:0] load_val;
   logic             q_is_top;
   logic             q_is_zero;
   logic             wrap_d;
   logic             wrap_q;

   assign dir = count_dir_t'(up_i);

   // ---------------------------------------------------------------------
   // Toggle-cell storage: each bit flips when its next value differs.
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      tff_cell u_tff (
         .clk   (clk),
         .reset (reset),
         .t_i   (toggle[i]),
         .q_o   (cnt_q[i]),
         .nq_o  (cnt_n[i])
      );
   end

   assign toggle = cnt_d ^ cnt_q;

   // Zero detect from the complement outputs: all nQ high means count is 0.
   assign q_is_zero = &cnt_n;
   assign q_is_top  = (cnt_q == TOP_VAL);

   // Out-of-range load values saturate at the terminal value.
   assign d_ext    = 64'(d_i);
   assign load_val = (d_ext < 64'(MODULUS)) ? d_i : TOP_VAL;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val;
      end else if (en_i) begin
         if (dir == DIR_UP) begin
            if (q_is_top) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (q_is_zero) begin
               cnt_d  = TOP_VAL;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

`ifdef MOD_COUNTER_STICKY_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Sets with the wrap pulse, survives load, dropped only by clr or reset.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_i) begin
         ovf_d = 1'b0;
      end else if (wrap_d) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf_o = ovf_q;
`else
   assign ovf_o = 1'b0;
`endif

   // tc is deliberately not gated by clr/load so cascades see a pure carry.
   assign tc_o   = en_i & ((dir == DIR_UP) ? q_is_top : q_is_zero);
   assign q_o    = cnt_q;
   assign wrap_o = wrap_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
// Bench for mod_counter: a WIDTH=4/MODULUS=10 unit plus two WIDTH=4/MODULUS=16
// stages cascaded into an 8-bit counter.
// -----------------------------------------------------------------------------
module tb_mod_counter;

   localparam int MOD = 10;
`ifdef MOD_COUNTER_STICKY_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // DUT signals
   // ------------------------------------------------------------------
   logic       clr = 0, en = 0, up = 1, load = 0;
   logic [3:0] d = '0;
   logic [3:0] q;
   logic       tc, wrap, ovf;

   logic       c_en = 0;
   logic       c_up = 1;
   logic [3:0] lo_q, hi_q;
   logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_ovf, hi_ovf;

   mod_counter #(.WIDTH(4), .MODULUS(MOD)) dut (
      .clk(clk), .reset(reset), .clr_i(clr), .en_i(en), .up_i(up),
      .load_i(load), .d_i(d), .q_o(q), .tc_o(tc), .wrap_o(wrap), .ovf_o(ovf)
   );

   mod_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
      .clk(clk), .reset(reset), .clr_i(1'b0), .en_i(c_en), .up_i(c_up),
      .load_i(1'b0), .d_i(4'd0), .q_o(lo_q), .tc_o(lo_tc), .wrap_o(lo_wrap),
      .ovf_o(lo_ovf)
   );

   mod_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
      .clk(clk), .reset(reset), .clr_i(1'b0), .en_i(lo_tc), .up_i(c_up),
      .load_i(1'b0), .d_i(4'd0), .q_o(hi_q), .tc_o(hi_tc), .wrap_o(hi_wrap),
      .ovf_o(hi_ovf)
   );

   // ------------------------------------------------------------------
   // Scoreboard counters
   // ------------------------------------------------------------------
   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: modular arithmetic on plain integers.
   // ------------------------------------------------------------------
   int m_cnt  = 0;
   bit m_wrap = 0;
   bit m_ovf  = 0;
   int c8     = 0;
   bit c_wrap = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt = 0; m_wrap = 0; m_ovf = 0; c8 = 0; c_wrap = 0;
      end else begin
         if (clr) begin
            m_cnt = 0; m_wrap = 0; m_ovf = 0;
         end else if (load) begin
            m_cnt  = (int'(d) < MOD) ? int'(d) : MOD - 1;
            m_wrap = 0;
         end else if (en) begin
            if (up) begin
               m_wrap = (m_cnt == MOD - 1);
               m_cnt  = (m_cnt + 1) % MOD;
            end else begin
               m_wrap = (m_cnt == 0);
               m_cnt  = (m_cnt + MOD - 1) % MOD;
            end
            if (m_wrap) m_ovf = OVF_ON;
         end else begin
            m_wrap = 0;
         end
         // Cascaded pair behaves as one 8-bit up counter.
         if (c_en) begin
            c_wrap = (c8 == 255);
            c8     = (c8 + 1) % 256;
         end else begin
            c_wrap = 0;
         end
      end
   end

   // Compare process: outputs settle well before the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         chk("model_q",    32'(q),    32'(m_cnt));
         chk("model_wrap", 32'(wrap), 32'(m_wrap));
         chk("model_ovf",  32'(ovf),  32'(m_ovf));
         chk("model_tc",   32'(tc),
             32'(en && (up ? (m_cnt == MOD - 1) : (m_cnt == 0))));
         chk("model_casc_q",    32'({hi_q, lo_q}), 32'(c8));
         chk("model_casc_wrap", 32'(hi_wrap),      32'(c_wrap));
      end
   end

   // ------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int up_seq[11]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int dn_seq[4]    = '{1, 0, 9, 8};
   int n_hi_wrap    = 0;

   initial begin
      // Reset state
      #1 reset = 1'b1;
      #2;
      chk("reset_q_async", 32'(q), 32'd0);
      repeat (3) tick();
      chk("reset_q",    32'(q),    32'd0);
      chk("reset_wrap", 32'(wrap), 32'd0);
      chk("reset_ovf",  32'(ovf),  32'd0);
      reset = 1'b0;

      // Count up 0..9,0,1
      up = 1; en = 1;
      for (int i = 0; i < 11; i++) begin
         tick();
         chk("up_q",    32'(q),    32'(up_seq[i]));
         chk("up_wrap", 32'(wrap), 32'(i == 9));
         chk("up_tc",   32'(tc),   32'(i == 8));
      end

      // Load 2, then count down 1,0,9,8
      en = 0; load = 1; d = 4'd2;
      tick();
      chk("load2_q", 32'(q), 32'd2);
      load = 0; en = 1; up = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("dn_q",    32'(q),    32'(dn_seq[i]));
         chk("dn_wrap", 32'(wrap), 32'(i == 2));
         chk("dn_tc",   32'(tc),   32'(i == 1));
      end

      // Load beats enable; out-of-range load saturates
      load = 1; d = 4'd7;
      tick();
      chk("load7_q", 32'(q), 32'd7);
      d = 4'd12;
      tick();
      chk("load12_sat_q", 32'(q), 32'd9);
      chk("ovf_after_load", 32'(ovf), 32'(OVF_ON));
      load = 0; en = 0; clr = 1;
      tick();
      chk("clr_q",   32'(q),   32'd0);
      chk("clr_ovf", 32'(ovf), 32'd0);
      clr = 0;

      // clr and load together at q=5
      load = 1; d = 4'd5;
      tick();
      chk("load5_q", 32'(q), 32'd5);
      clr = 1;
      tick();
      chk("clr_load_q", 32'(q), 32'd0);
      clr = 0; load = 0;

      // Wrap up from 9, then reset mid-cycle
      load = 1; d = 4'd9;
      tick();
      load = 0; en = 1; up = 1;
      tick();
      chk("wrap_pre_q",    32'(q),    32'd0);
      chk("wrap_pre_wrap", 32'(wrap), 32'd1);
      chk("wrap_pre_ovf",  32'(ovf),  32'(OVF_ON));
      #1 reset = 1'b1;
      #1;
      chk("mid_reset_q",    32'(q),    32'd0);
      chk("mid_reset_wrap", 32'(wrap), 32'd0);
      chk("mid_reset_ovf",  32'(ovf),  32'd0);
      #1 reset = 1'b0;
      tick();
      chk("post_reset_q", 32'(q), 32'd1);

      // Mixed directed/random traffic, checked against the model
      for (int i = 0; i < 40; i++) begin
         en   = 1'($urandom_range(0, 1));
         up   = 1'($urandom_range(0, 1));
         load = ($urandom_range(0, 7) == 0);
         clr  = ($urandom_range(0, 11) == 0);
         d    = 4'($urandom_range(0, 15));
         tick();
      end
      en = 0; load = 0; clr = 0;

      // Cascaded 8-bit count to 0xFF and over to 0x00
      c_en = 1;
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (hi_wrap) n_hi_wrap++;
         if (i == 255) chk("casc_ff", 32'({hi_q, lo_q}), 32'h0ff);
         if (i == 256) begin
            chk("casc_00",   32'({hi_q, lo_q}), 32'h000);
            chk("casc_wrap", 32'(hi_wrap),      32'd1);
         end
      end
      c_en = 0;
      tick();
      chk("casc_wrap_count", 32'(n_hi_wrap), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mod_counter
